// File: rtl/alu_md_pkg.sv
// alu_md_pkg: op encodings, FSM states and counter sizing shared by the multiply/divide unit.
package alu_md_pkg;
   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} md_state_e;
   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction
endpackage

// File: rtl/md_abs_neg.sv
// md_abs_neg: conditional two's-complement negation, used for operand magnitudes and result sign fix.
module md_abs_neg #(
   parameter int WIDTH = 32
) (
   input  logic             i_neg,
   input  logic [WIDTH-1:0] i_x,
   output logic [WIDTH-1:0] o_y
);
   assign o_y = i_neg ? -i_x : i_x;
endmodule

// File: rtl/alu_md.sv
// alu_md: iterative radix-2 MULT/MULTU/DIV/DIVU unit producing the HI/LO pair.
// Divider built only with ALU_MD_DIV_EN; without it DIV/DIVU finish in one cycle with zero results.
module alu_md
   import alu_md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);
   localparam int CNT_W = cnt_w(WIDTH);
   md_state_e          r_state, w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_sq, r_short, r_dz;
   logic [WIDTH-1:0]   r_b, r_hi, r_lo, w_abs_a, w_abs_b, w_hi;
   logic [2*WIDTH-1:0] r_acc, w_fix_in, w_fix;
   logic [WIDTH:0]     w_madd;
   logic               w_accept, w_is_div, w_sgn, w_short;
   assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_is_div = (op == OP_DIVU) || (op == OP_DIV);
   assign w_sgn    = (op == OP_MULT) || (op == OP_DIV);
   assign w_madd   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
   md_abs_neg #(.WIDTH(WIDTH)) u_abs_a (.i_neg(w_sgn && a[WIDTH-1]), .i_x(a), .o_y(w_abs_a));
   md_abs_neg #(.WIDTH(WIDTH)) u_abs_b (.i_neg(w_sgn && b[WIDTH-1]), .i_x(b), .o_y(w_abs_b));
   md_abs_neg #(.WIDTH(2*WIDTH)) u_fix (.i_neg(r_sq), .i_x(w_fix_in), .o_y(w_fix));
`ifdef ALU_MD_DIV_EN
   logic               r_mul, r_sr;
   logic [WIDTH:0]     r_rem, w_sh, w_diff;
   logic [WIDTH-1:0]   w_rem_fix;
   assign w_short  = w_is_div && (b == '0);
   assign w_sh     = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
   assign w_diff   = w_sh - {1'b0, r_b};
   // quotient lives in the low half of the accumulator, so one 2*WIDTH negator serves both ops
   assign w_fix_in = r_mul ? r_acc : {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]};
   assign w_hi     = r_mul ? w_fix[2*WIDTH-1:WIDTH] : w_rem_fix;
   md_abs_neg #(.WIDTH(WIDTH)) u_rem (.i_neg(r_sr), .i_x(r_rem[WIDTH-1:0]), .o_y(w_rem_fix));
`else
   assign w_short  = w_is_div;
   assign w_fix_in = r_acc;
   assign w_hi     = w_fix[2*WIDTH-1:WIDTH];
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= S_IDLE;
      else r_state <= w_next;
   always_comb begin
      w_next = r_state;
      if (w_accept) w_next = w_short ? S_DONE : S_CALC;
      else if (r_state == S_CALC && r_cnt == CNT_W'(1)) w_next = S_FIX;
      else if (r_state == S_FIX) w_next = S_DONE;
      else if (r_state == S_DONE) w_next = S_IDLE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_cnt   <= '0;
         r_sq    <= 1'b0;
         r_short <= 1'b0;
         r_b     <= '0;
         r_acc   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_dz    <= 1'b0;
`ifdef ALU_MD_DIV_EN
         r_mul   <= 1'b0;
         r_sr    <= 1'b0;
         r_rem   <= '0;
`endif
      end else if (w_accept) begin
         r_cnt   <= CNT_W'(WIDTH);
         r_sq    <= w_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
         r_short <= w_short;
         r_b     <= w_abs_b;
         r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
`ifdef ALU_MD_DIV_EN
         r_mul   <= !w_is_div;
         r_sr    <= w_sgn && a[WIDTH-1];
         r_rem   <= '0;
         if (w_short) begin
            r_hi <= a;
            r_lo <= '1;
            r_dz <= 1'b1;
         end
`else
         if (w_short) begin
            r_hi <= '0;
            r_lo <= '0;
            r_dz <= 1'b0;
         end
`endif
      end else if (r_state == S_CALC) begin
         r_cnt <= r_cnt - CNT_W'(1);
`ifdef ALU_MD_DIV_EN
         if (r_mul) r_acc <= {w_madd, r_acc[WIDTH-1:1]};
         else begin
            r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], ~w_diff[WIDTH]};
            r_rem <= w_diff[WIDTH] ? w_sh : w_diff;
         end
`else
         r_acc <= {w_madd, r_acc[WIDTH-1:1]};
`endif
      end else if (r_state == S_FIX) begin
         r_hi <= w_hi;
         r_lo <= w_fix[WIDTH-1:0];
         r_dz <= 1'b0;
      end
   // a start accepted in the DONE cycle keeps busy high with no gap
   assign busy     = (r_state == S_CALC) || (r_state == S_FIX) || (r_state == S_DONE && (r_short || start));
   assign done     = (r_state == S_DONE);
   assign hi       = r_hi;
   assign lo       = r_lo;
   assign div_zero = r_dz;
endmodule

// File: doc/alu_md.md
# alu_md

Iterative multiply/divide unit that extends the CPU datapath's combinational ALU with MULT, MULTU, DIV and DIVU. It uses a radix-2 shift-add and shift-subtract engine with a parametrised operand width. It sits beside the ALU in the execute stage and writes the HI/LO pair. The pipeline controller stalls on `busy` and samples results on `done`.

## Interface
Parameters:
- WIDTH, 32, operand width; must be even and at least 8.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous and active-low.
- start  in  1  request; sampled only when the unit is ready.
- op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  in  WIDTH  multiplicand or dividend.
- b  in  WIDTH  multiplier or divisor.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; hi, lo and div_zero are valid from this cycle onward.
- hi  out  WIDTH  MULT: upper half of the product. DIV: remainder.
- lo  out  WIDTH  MULT: lower half of the product. DIV: quotient.
- div_zero  out  1  divisor was zero for the last completed DIV or DIVU.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- Accepting a request:
  - A request is accepted when start=1 and the state is IDLE or DONE (back-to-back issue allowed).
  - On acceptance, op, a and b are latched; later changes to the inputs are ignored.
  - start during CALC or FIX is ignored; it is not queued.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitudes at acceptance.
  - Result signs are recorded: product and quotient sign = a[W-1]^b[W-1]; remainder sign = a[W-1].
- CALC: exactly WIDTH iterations, one per cycle.
  - Multiply: 2·WIDTH accumulator, conditional add of b, then shift right.
  - Divide: restoring shift-subtract; the remainder register is WIDTH+1 bits.
- FIX: applies two's-complement negation per the recorded signs, then loads hi/lo.
- DONE: done=1 for one cycle; then returns to IDLE, or to CALC if a new start was accepted.
- Divide by zero (b==0, DIVU or DIV):
  - CALC and FIX are skipped; the FSM goes IDLE→DONE.
  - Results: lo = all ones, hi = a unchanged (latched value), div_zero=1.
- Signed overflow: DIV of the most-negative value by -1 gives lo = most-negative value, hi = 0, div_zero=0. No trap.
- div_zero is cleared on every completing MULT, MULTU, or divide with a nonzero divisor.
- hi, lo and div_zero hold between done pulses.

## Timing
- Reset values: state IDLE, busy=0, done=0, hi=0, lo=0, div_zero=0.
- Reset asserted mid-operation aborts the op immediately; the outputs return to their reset values.
- Latency for accept at edge N:
  - busy=1 from N+1.
  - CALC covers N+1..N+WIDTH.
  - FIX at N+WIDTH+1.
  - done=1 in cycle N+WIDTH+2.
  - hi/lo update on the same edge that raises done.
- Divide-by-zero latency: done=1 in cycle N+1; busy=1 for that cycle only.
- busy deasserts in the DONE cycle, unless a new start is accepted in that cycle, in which case busy stays 1 continuously.
- Throughput: one op per WIDTH+2 cycles.

## Configuration
- Macro: ALU_MD_DIV_EN.
- Defined: full behaviour as above.
- Undefined:
  - Divider datapath and remainder register are not built.
  - DIV and DIVU complete via IDLE→DONE in one cycle with hi=0, lo=0, div_zero=0.
  - MULT and MULTU are unchanged.

## Structure
- Package alu_md_pkg holds:
  - op encoding constants (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV);
  - FSM state enum;
  - localparam CNT_W = $clog2(WIDTH+1).
- One sub-module, md_abs_neg: combinational conditional two's-complement, parametrised by WIDTH. It is instantiated for operand magnitude and for result sign fix.
- Iteration counter is CNT_W bits and counts down from WIDTH.

## Test plan
All scenarios use WIDTH=32.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after the accept edge.
- MULT a=-3, b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 → done in the next cycle, div_zero=1, lo=0xFFFFFFFF, hi=0x00000064. A following MULTU 2×3 clears div_zero, giving lo=6.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, div_zero=0.
- start with new operands mid-CALC → ignored and first result unchanged. start in the DONE cycle → accepted and busy held high.
- rst_n low at CALC iteration 10 → busy, done, hi and lo go to 0 asynchronously. A new MULTU 7×6 after release → lo=42.
